// File: rtl/uart_tx_packetizer.sv
// Frames status/response messages as SOF, CMD, LEN, payload[, checksum] bytes into the UART TX FIFO.
// Define TX_PKT_CHECKSUM_EN to append the 8-bit modular checksum byte (CHK state).
module uart_tx_packetizer #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SOF_BYTE      = 8'hAA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_cmd,
  input  logic [7:0]                 req_len,
  input  logic [8*PAYLOAD_BYTES-1:0] req_payload,
  output logic [7:0]                 tx_data,
  output logic                       push,
  input  logic                       tx_fifo_full,
  output logic                       busy,
  output logic                       pkt_done,
  output logic [2:0]                 dbg_state
);

  localparam int IW = $clog2(PAYLOAD_BYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF  = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4
`ifdef TX_PKT_CHECKSUM_EN
    , S_CHK = 3'd5
`endif
  } state_t;

`ifdef TX_PKT_CHECKSUM_EN
  localparam state_t TAIL         = S_CHK;
  localparam logic   TAIL_IS_IDLE = 1'b0;
  logic [7:0] chk_q;
`else
  localparam state_t TAIL         = S_IDLE;
  localparam logic   TAIL_IS_IDLE = 1'b1;
`endif

  state_t                     state;
  logic [7:0]                 cmd_q;
  logic [IW-1:0]              len_q;
  logic [IW-1:0]              idx_q;
  logic [IW-1:0]              len_clamped;
  logic [8*PAYLOAD_BYTES-1:0] pay_q;
  logic                       emitting;
  logic                       last_data;

  // Handshakes: a request is taken on a rising edge with req_valid & req_ready;
  // a byte is written to the FIFO on every rising edge where push is high, and
  // push is never high while tx_fifo_full is high.
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign emitting  = (state != S_IDLE);
  assign push      = emitting & ~tx_fifo_full;
  assign dbg_state = state;

  assign len_clamped = (req_len > 8'(PAYLOAD_BYTES)) ? IW'(PAYLOAD_BYTES) : IW'(req_len);
  assign last_data   = (idx_q == len_q - IW'(1));

  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_SOF:  tx_data = SOF_BYTE;
      S_CMD:  tx_data = cmd_q;
      S_LEN:  tx_data = 8'(len_q);
      S_DATA: tx_data = pay_q[7:0];
`ifdef TX_PKT_CHECKSUM_EN
      S_CHK:  tx_data = chk_q;
`endif
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd_q    <= 8'h00;
      len_q    <= '0;
      idx_q    <= '0;
      pay_q    <= '0;
      pkt_done <= 1'b0;
`ifdef TX_PKT_CHECKSUM_EN
      chk_q    <= 8'h00;
`endif
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q <= req_cmd;
            len_q <= len_clamped;
            pay_q <= req_payload;
            idx_q <= '0;
`ifdef TX_PKT_CHECKSUM_EN
            chk_q <= 8'h00;
`endif
            state <= S_SOF;
          end
        end
        S_SOF: if (push) state <= S_CMD;
        S_CMD: if (push) state <= S_LEN;
        S_LEN: begin
          if (push) begin
            if (len_q == '0) begin
              state    <= TAIL;
              pkt_done <= TAIL_IS_IDLE;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Payload is shifted out so the current byte always sits in the low lane.
          if (push) begin
            pay_q <= pay_q >> 8;
            idx_q <= idx_q + IW'(1);
            if (last_data) begin
              state    <= TAIL;
              pkt_done <= TAIL_IS_IDLE;
            end
          end
        end
`ifdef TX_PKT_CHECKSUM_EN
        S_CHK: begin
          if (push) begin
            state    <= S_IDLE;
            pkt_done <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
`ifdef TX_PKT_CHECKSUM_EN
      // SOF is excluded from the sum; CMD, LEN and payload are folded in as pushed.
      if (push && (state == S_CMD || state == S_LEN || state == S_DATA))
        chk_q <= chk_q + tx_data;
`endif
    end
  end

endmodule

// File: doc/uart_tx_packetizer.md
# uart_tx_packetizer

Frames plotter status/response messages into bytes and pushes them into the UART transmit FIFO stage, which serializes them to the host PC. Sits directly upstream of that stage: it drives the FIFO's byte input and push strobe and stalls on the FIFO-full flag. Each accepted request becomes one packet: SOF, CMD, LEN, payload bytes, and an optional checksum.

## Interface
- PAYLOAD_BYTES, 4: maximum payload bytes per packet (1..255).
- SOF_BYTE, 8'hAA: start-of-frame byte emitted first in every packet.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_cmd  input  8  command/status code.
- req_len  input  8  requested payload byte count; values above PAYLOAD_BYTES are clamped.
- req_payload  input  8*PAYLOAD_BYTES  payload; byte i = req_payload[8*i +: 8], byte 0 sent first.
- tx_data  output  8  byte to the FIFO push port.
- push  output  1  FIFO write strobe; one byte written per cycle high.
- tx_fifo_full  input  1  FIFO full flag from the downstream stage.
- busy  output  1  packet in progress (state != IDLE).
- pkt_done  output  1  one-cycle pulse after the last byte of a packet is pushed.

## Operation
- States: IDLE, SOF, CMD, LEN, DATA, CHK.
- IDLE: req_ready=1. On req_valid & req_ready, the block:
  - registers cmd, the clamped length L = min(req_len, PAYLOAD_BYTES), and the full payload;
  - clears the byte index and the checksum;
  - goes to SOF.
- Each emitting state (SOF..CHK) presents its byte on tx_data. push = emitting & ~tx_fifo_full, combinational from registered state and tx_fifo_full.
- The state or index advances only in a cycle where push=1.
- SOF sends SOF_BYTE, then CMD. CMD sends cmd, then LEN. LEN sends L, then DATA if L>0, otherwise CHK (or IDLE when the checksum is compiled out).
- DATA sends payload[index] and increments index. After index L-1 it goes to CHK (or IDLE).
- CHK sends the checksum, then IDLE.
- Checksum: 8-bit modular sum (carry discarded) of the CMD byte, the LEN byte (clamped value) and all payload bytes. SOF is excluded. It is accumulated on each push.
- Byte index width: $clog2(PAYLOAD_BYTES)+1 bits. It never exceeds L.
- pkt_done is registered. It is high the cycle after the final push, coinciding with the return to IDLE.
- Request inputs are ignored while busy. A new request is never captured mid-packet.

## Timing
- Reset values:
  - req_ready=1, push=0, tx_data=8'h00, busy=0, pkt_done=0.
  - State=IDLE, index=0, checksum=0.
- Acceptance to first push (SOF): 1 cycle. The SOF push happens the cycle after the handshake.
- With no backpressure, bytes are pushed on consecutive cycles: 4+L cycles per packet (3+L with checksum compiled out).
- Back-to-back packets: the earliest next acceptance is in the IDLE cycle after the final push. That gives one idle gap cycle between packets.
- Backpressure: while tx_fifo_full=1, push=0 and tx_data, state, index and checksum hold. Bytes are never duplicated or dropped.
- tx_fifo_full may toggle on any cycle, including during SOF or CHK.
- Reset mid-packet: push drops to 0 immediately (asynchronously) and the block returns to IDLE. Bytes already in the FIFO are not retracted. After reset release the next packet starts with SOF.
- req_len=0 gives a header-only packet. req_len>PAYLOAD_BYTES sends exactly PAYLOAD_BYTES payload bytes, and the LEN field carries the clamped value.

## Configuration
- TX_PKT_CHECKSUM_EN defined: CHK state present; checksum byte appended; packet length 4+L.
- TX_PKT_CHECKSUM_EN undefined:
  - no CHK state and no checksum register; packets end after the last payload byte (or after LEN when L=0);
  - packet length 3+L; pkt_done follows the final DATA/LEN push.

## Test plan
- Reset: assert reset mid-simulation -> req_ready=1, push=0, busy=0, pkt_done=0, tx_data=00.
- cmd=21, len=2, payload bytes 34,12, full=0 -> pushes AA,21,02,34,12,69 on 6 consecutive cycles; pkt_done pulses the next cycle.
- cmd=05, len=0 -> pushes AA,05,00,05; req_ready returns the cycle after the last push.
- Backpressure: same packet as scenario 2, with tx_fifo_full=1 for 3 cycles while 34 is presented -> push=0 and tx_data=34 held for those 3 cycles; the stream completes as AA,21,02,34,12,69 with no duplicates.
- Clamp (PAYLOAD_BYTES=4): cmd=10, len=9, bytes 01,02,03,04 -> AA,10,04,01,02,03,04,1E.
- Reset asserted during DATA -> push=0 in the same cycle. After release, a new request cmd=05, len=0 yields AA,05,00,05. With TX_PKT_CHECKSUM_EN undefined, scenario 2 yields AA,21,02,34,12 only.
